// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with a multi-cycle execute countdown.
// Optional saturating stall-cycle counter when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            ex_mc_start,
    input  logic [MC_W-1:0] ex_mc_cycles,
    input  logic            flush_req,
    output logic [5:0]      stall,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     stall_cnt
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] MC    = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    logic [1:0]      state, state_nx;
    logic [MC_W-1:0] cnt, cnt_nx;
    logic            mc_now;
    // Reset masks the combinational response so outputs read idle while rst is low.
    always_comb begin
        flush    = rst && (state == FLUSH || flush_req);
        mc_now   = rst && !flush && (state == MC || ex_mc_start);
        stall    = mc_now ? 6'b001111 : (rst && !flush && stallreq_id) ? 6'b000111 : 6'b000000;
        busy     = state != RUN;
        state_nx = RUN;
        cnt_nx   = '0;
        if (state == FLUSH) begin
            state_nx = RUN;
        end else if (flush_req) begin
            state_nx = FLUSH;
        end else if (state == MC) begin
            state_nx = (cnt == MC_W'(1)) ? RUN : MC;
            cnt_nx   = cnt - MC_W'(1);
        end else if (ex_mc_start && ex_mc_cycles > MC_W'(1)) begin
            state_nx = MC;
            cnt_nx   = ex_mc_cycles - MC_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stat_q <= '0;
        else if (stall != 6'b000000 && stat_q != 16'hFFFF)
            stat_q <= stat_q + 16'd1;
    end
    assign stall_cnt = stat_q;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_W, default 6: width of the multi-cycle length input and the internal countdown.
REQ-002 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  in  1  reset, asynchronous and active-low.
REQ-004 Port stallreq_id  in  1  load-use hazard from decode; level, one bubble per asserted cycle.
REQ-005 Port ex_mc_start  in  1  one-cycle pulse from execute starting a multi-cycle operation (div/madd).
REQ-006 Port ex_mc_cycles  in  MC_W  total execute cycles N of that operation; valid only with ex_mc_start.
REQ-007 Port flush_req  in  1  exception/redirect flush request; level, sampled each cycle.
REQ-008 Port stall  out  6  per-stage hold: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb.
REQ-009 Port flush  out  1  clear all pipeline registers.
REQ-010 Port busy  out  1  high whenever the FSM is not in RUN.
REQ-011 Port stall_cnt  out  16  stalled-cycle counter (see Configuration).

Function
REQ-012 FSM states SHALL be RUN, MC, FLUSH; state and countdown cnt are registered, stall/flush decoded combinationally from state and current inputs.
REQ-013 Priority in every cycle SHALL be flush_req > multi-cycle (ex_mc_start or MC) > stallreq_id.
REQ-014 RUN, no request: stall=6'b000000, flush=0.
REQ-015 RUN, stallreq_id only: stall=6'b000111 in that same cycle; state stays RUN.
REQ-016 RUN, ex_mc_start with N>=2: stall=6'b001111 that cycle; next state MC with cnt=N-1.
REQ-017 RUN, ex_mc_start with N=0 or N=1: one-cycle stall 6'b001111; state stays RUN.
REQ-018 MC: stall=6'b001111; cnt decrements each cycle; cnt==1 -> next state RUN; total stalled cycles = N including start cycle.
REQ-019 MC: ex_mc_start and stallreq_id SHALL be ignored (no restart, no reload).
REQ-020 flush_req in RUN or MC: flush=1, stall=0 that cycle; next state FLUSH; cnt cleared (multi-cycle op aborted).
REQ-021 FLUSH: flush=1, stall=0 for exactly one cycle; all requests ignored; next state RUN regardless of flush_req.
REQ-022 Flush window SHALL therefore be two cycles per flush event; flush_req held longer retriggers from RUN on the cycle after FLUSH.
REQ-023 cnt arithmetic SHALL be MC_W-bit unsigned; no wrap possible since MC exits at cnt==1 and N<2 never enters MC.

Reset
REQ-024 While rst=0: state=RUN, cnt=0, stall_cnt=0, so stall=6'b000000, flush=0, busy=0 (except combinational response to inputs is suppressed: stall=0, flush=0).
REQ-025 Reset asserted mid-MC or mid-FLUSH SHALL abort immediately; first cycle after deassertion is RUN.

Configuration
REQ-026 Macro PIPE_CTRL_STATS_EN defined: stall_cnt increments by 1 on each clock where stall!=0, saturating at 16'hFFFF; cleared only by reset.
REQ-027 Macro PIPE_CTRL_STATS_EN undefined: no counter logic; stall_cnt tied to 16'h0000.

Verification
REQ-028 stallreq_id=1 for 3 cycles in RUN -> stall=6'b000111 for exactly those 3 cycles, busy=0 throughout.
REQ-029 ex_mc_start pulse with ex_mc_cycles=5 -> stall=6'b001111 for 5 consecutive cycles, busy=1 for cycles 2-5, then stall=0.
REQ-030 ex_mc_start N=5, flush_req=1 on third stalled cycle -> flush=1 that cycle and next, stall=0 from that cycle, then RUN with no residual stall.
REQ-031 ex_mc_start N=1 together with stallreq_id=1 -> single cycle stall=6'b001111, then stall=0; ex_mc_start N=0 -> identical.
REQ-032 rst=0 asserted during MC cycle 2 of N=10 -> stall=0, busy=0 immediately; after release with no requests stall stays 0.
REQ-033 With PIPE_CTRL_STATS_EN: 70000 stalled cycles -> stall_cnt=16'hFFFF and holds; without macro -> stall_cnt=0 always.
